// File: rtl/spi_mem_pkg.sv
// Shared constants and types for the SPI serial-memory slave: opcodes, address
// widths per personality and the transaction state encoding.
package spi_mem_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    localparam int ADDR_W_FLASH = 24;
    localparam int ADDR_W_RAM   = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_WRITE,
        ST_IGNORE
    } state_t;

    // Index of the final address bit for the selected personality.
    function automatic logic [4:0] addr_last(input logic flash);
        return flash ? 5'(ADDR_W_FLASH - 1) : 5'(ADDR_W_RAM - 1);
    endfunction

endpackage

// File: rtl/spi_mem_sync.sv
// Brings the asynchronous SPI pins into the clk domain and turns spi_clk and
// spi_ce transitions into single-cycle rise/fall pulses.
module spi_mem_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_ce,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ce_rise,
    output logic ce_fall
);

    logic [2:0] sclk_ff;
    logic [2:0] ce_ff;
    logic [1:0] mosi_ff;

    // Chip enable resets to its inactive (high) level so reset release never
    // fabricates a transaction start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff <= 3'b000;
            ce_ff   <= 3'b111;
            mosi_ff <= 2'b00;
        end else begin
            sclk_ff <= {sclk_ff[1:0], spi_clk};
            ce_ff   <= {ce_ff[1:0], spi_ce};
            mosi_ff <= {mosi_ff[0], spi_mosi};
        end
    end

    assign mosi_s    = mosi_ff[1];
    assign sclk_rise =  sclk_ff[1] & ~sclk_ff[2];
    assign sclk_fall = ~sclk_ff[1] &  sclk_ff[2];
    assign ce_rise   =  ce_ff[1]   & ~ce_ff[2];
    assign ce_fall   = ~ce_ff[1]   &  ce_ff[2];

endmodule

// File: rtl/spi_memory.sv
// SPI mode-0 serial-memory slave (read-only 24-bit flash or 16-bit R/W SRAM).
module spi_memory
    import spi_mem_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter     INIT_FILE = ""
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_ce,
    output logic spi_miso,
    input  logic is_flash
);

    logic mosi_s, sclk_rise, sclk_fall, ce_rise, ce_fall;

    spi_mem_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_ce    (spi_ce),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ce_rise   (ce_rise),
        .ce_fall   (ce_fall)
    );

    logic [7:0]           mem [2**ADDR_BITS];
    state_t               state;
    logic [4:0]           bit_cnt;
    logic [ADDR_BITS-2:0] shift;
    logic [ADDR_BITS-1:0] addr;
    logic                 is_write;
    logic [7:0]           rx_byte;
    logic                 wr_en;

    // The shifter only keeps the low address bits, so long addresses wrap for free.
    assign rx_byte = {shift[6:0], mosi_s};
    assign wr_en   = (state == ST_WRITE) && sclk_rise && !ce_rise && (bit_cnt == 5'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            addr     <= '0;
            is_write <= 1'b0;
            spi_miso <= 1'b0;
        end else if (ce_rise) begin
            // Deselect beats any simultaneous spi_clk edge and drops partial bytes.
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            spi_miso <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ce_fall) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shift   <= {shift[ADDR_BITS-3:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            if (rx_byte == CMD_READ) begin
                                state    <= ST_ADDR;
                                is_write <= 1'b0;
                            end else if (rx_byte == CMD_WRITE && !is_flash) begin
                                state    <= ST_ADDR;
                                is_write <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        shift   <= {shift[ADDR_BITS-3:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == addr_last(is_flash)) begin
                            addr    <= {shift, mosi_s};
                            bit_cnt <= '0;
                            state   <= is_write ? ST_WRITE : ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (sclk_fall) begin
                        spi_miso <= mem[addr][~bit_cnt[2:0]];
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr + 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (sclk_rise) begin
                        shift   <= {shift[ADDR_BITS-3:0], mosi_s};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            addr    <= addr + 1'b1;
                        end
                    end
                end
                ST_IGNORE: spi_miso <= 1'b0;
                default:   state    <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the byte array has no reset so it maps onto plain RAM storage; its
    // contents persist across rst_n and are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr] <= rx_byte;
    end

endmodule

// File: tb/tb_spi_memory.sv
// Directed bench for spi_memory: RAM write/read, wrap, aborted write, flash
// read and ignored flash write, and reset during a read stream.
module tb_spi_memory;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic spi_clk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_ce = 1'b1;
    logic spi_miso;
    logic is_flash = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    spi_memory #(.ADDR_BITS(12)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_ce   (spi_ce),
        .spi_miso (spi_miso),
        .is_flash (is_flash)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Mode 0: master samples miso just before each rise; spi_clk half period is 4 clk.
    task automatic xfer_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = tx[i];
            #40;
            rx[i] = spi_miso;
            spi_clk = 1'b1;
            #40;
            spi_clk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic cs_low();
        spi_ce = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        #40;
        spi_ce = 1'b1;
        #80;
    endtask

    // Opcode plus address bytes; returns the OR of everything seen on miso.
    task automatic header(input logic [7:0] op, input logic [23:0] a, input int abytes,
                          output logic [7:0] orx);
        logic [7:0] r;
        xfer(op, r);
        orx = r;
        for (int k = abytes - 1; k >= 0; k--) begin
            xfer(a[8*k +: 8], r);
            orx |= r;
        end
    endtask

    initial begin
        logic [7:0] o, r0, r1;

        #33;
        check("reset_miso", {7'b0, spi_miso}, 8'h00);
        rst_n = 1'b1;
        #80;

        // RAM write two bytes at 0x0010, then read them back
        cs_low(); header(8'h02, 24'h000010, 2, o); xfer(8'hA5, r0); xfer(8'h5A, r1); cs_high();
        check("ram_write_hdr_miso", o, 8'h00);
        cs_low(); header(8'h03, 24'h000010, 2, o);
        check("ram_read_hdr_miso", o, 8'h00);
        xfer(8'h00, r0); xfer(8'h00, r1); cs_high();
        check("ram_read_b0", r0, 8'hA5);
        check("ram_read_b1", r1, 8'h5A);
        check("idle_miso", {7'b0, spi_miso}, 8'h00);

        // Write across the top of a 4 KiB array; the second byte lands at 0x000
        cs_low(); header(8'h02, 24'h000FFF, 2, o); xfer(8'hC3, r0); xfer(8'h3C, r1); cs_high();
        cs_low(); header(8'h03, 24'h000FFF, 2, o); xfer(8'h00, r0); xfer(8'h00, r1); cs_high();
        check("wrap_b0", r0, 8'hC3);
        check("wrap_b1", r1, 8'h3C);
        cs_low(); header(8'h03, 24'h000000, 2, o); xfer(8'h00, r0); cs_high();
        check("wrap_at_zero", r0, 8'h3C);
        cs_low(); header(8'h03, 24'h00FFFF, 2, o); xfer(8'h00, r0); cs_high();
        check("addr_truncate_ram", r0, 8'hC3);

        // Unknown opcode on RAM is ignored with miso held low
        cs_low(); header(8'h9F, 24'h000010, 2, o); xfer(8'h00, r0); cs_high();
        check("ram_bad_op_miso", o | r0, 8'h00);

        // Aborted second write byte leaves 0x21 untouched
        cs_low(); header(8'h02, 24'h000020, 2, o); xfer(8'hEE, r0); xfer(8'hEE, r1); cs_high();
        cs_low(); header(8'h02, 24'h000020, 2, o); xfer(8'h11, r0); xfer_bits(8'h22, 4, r1); cs_high();
        cs_low(); header(8'h03, 24'h000020, 2, o); xfer(8'h00, r0); xfer(8'h00, r1); cs_high();
        check("abort_b0", r0, 8'h11);
        check("abort_b1", r1, 8'hEE);

        // Seed flash image through the RAM personality, then switch to flash
        cs_low(); header(8'h02, 24'h000000, 2, o); xfer(8'h12, r0); xfer(8'h34, r1); cs_high();
        is_flash = 1'b1;
        #80;
        cs_low(); header(8'h03, 24'h000000, 3, o); xfer(8'h00, r0); xfer(8'h00, r1); cs_high();
        check("flash_hdr_miso", o, 8'h00);
        check("flash_b0", r0, 8'h12);
        check("flash_b1", r1, 8'h34);
        cs_low(); header(8'h03, 24'hFFF000, 3, o); xfer(8'h00, r0); cs_high();
        check("addr_truncate_flash", r0, 8'h12);

        // Write opcode on flash is ignored and must not modify the array
        cs_low(); header(8'h02, 24'h000000, 3, o); xfer(8'hFF, r0); cs_high();
        check("flash_write_miso", o | r0, 8'h00);
        cs_low(); header(8'h03, 24'h000000, 3, o); xfer(8'h00, r0); xfer(8'h00, r1); cs_high();
        check("flash_unchanged_b0", r0, 8'h12);
        check("flash_unchanged_b1", r1, 8'h34);

        // Reset mid-read: A5 after two bits has bit5 (=1) on miso
        is_flash = 1'b0;
        #80;
        cs_low(); header(8'h03, 24'h000010, 2, o); xfer_bits(8'h00, 2, r0);
        #40;
        check("pre_reset_miso", {7'b0, spi_miso}, 8'h01);
        rst_n = 1'b0;
        #1;
        check("reset_mid_read_miso", {7'b0, spi_miso}, 8'h00);
        spi_ce = 1'b1;
        #19;
        #80;
        rst_n = 1'b1;
        #80;
        cs_low(); header(8'h03, 24'h000011, 2, o); xfer(8'h00, r0); cs_high();
        check("post_reset_read", r0, 8'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
